// File: rtl/rf_pkg.sv
// Shared definitions for the register file: sizes and word/address types.
// No ports; imported by rf and rf_reg.
package rf_pkg;

   localparam int unsigned RF_DATA_W = 32;
   localparam int unsigned RF_ADDR_W = 5;
   localparam int unsigned RF_DEPTH  = 32;

   typedef logic [RF_DATA_W-1:0] rf_word_t;
   typedef logic [RF_ADDR_W-1:0] rf_addr_t;

endpackage

// File: rtl/rf_reg.sv
// One register-file entry: a W-bit register with asynchronous active-high
// clear and a synchronous load enable.
// Ports:
//   clk   - rising-edge clock
//   reset - async active-high clear
//   load  - 1 = capture d on the rising edge
//   d     - data in
//   q     - registered data out
module rf_reg
   import rf_pkg::*;
#(
   parameter int unsigned W = RF_DATA_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/rf.sv
// 32 x 32 general-purpose register file: two combinational read ports,
// one synchronous write port, entry 0 hardwired to zero.
// Ports:
//   clk      - rising-edge clock for writes
//   reset    - async active-high clear of all entries
//   we       - write enable
//   r1a, r2a - read addresses
//   wa, wd   - write address / data
//   r1d, r2d - read data (= reg[r1a], reg[r2a]), no write bypass
module rf
   import rf_pkg::*;
#(
   parameter int unsigned DATA_W = RF_DATA_W,
   parameter int unsigned ADDR_W = RF_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] r1a,
   input  logic [ADDR_W-1:0] r2a,
   input  logic [ADDR_W-1:0] wa,
   input  logic [DATA_W-1:0] wd,
   output logic [DATA_W-1:0] r1d,
   output logic [DATA_W-1:0] r2d
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs [DEPTH];
   logic [DEPTH-1:1]  load;

   // One-hot write decode; entry 0 has no storage so it never loads.
   always_comb begin
      load = '0;
      for (int unsigned i = 1; i < DEPTH; i++) begin
         load[i] = we && (wa == ADDR_W'(i));
      end
   end

   assign regs[0] = '0;

   for (genvar g = 1; g < DEPTH; g++) begin : g_entry
      rf_reg #(.W(DATA_W)) u_reg (
         .clk   (clk),
         .reset (reset),
         .load  (load[g]),
         .d     (wd),
         .q     (regs[g])
      );
   end

   // Combinational read muxes; the read sees the old value until the write edge.
   assign r1d = regs[r1a];
   assign r2d = regs[r2a];

endmodule

// File: tb/tb_rf.sv
module tb_rf;
   import rf_pkg::*;

   logic     clk = 1'b0;
   logic     reset = 1'b0;
   logic     we = 1'b0;
   rf_addr_t r1a = '0;
   rf_addr_t r2a = '0;
   rf_addr_t wa = '0;
   rf_word_t wd = '0;
   rf_word_t r1d;
   rf_word_t r2d;

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;

   rf #(.DATA_W(RF_DATA_W), .ADDR_W(RF_ADDR_W)) dut (
      .clk   (clk),
      .reset (reset),
      .we    (we),
      .r1a   (r1a),
      .r2a   (r2a),
      .wa    (wa),
      .wd    (wd),
      .r1d   (r1d),
      .r2d   (r2d)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input rf_word_t got, input rf_word_t exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance to 1 time unit past the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // 1: reset clears everything
      #2 reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 32; i++) begin
         r1a = rf_addr_t'(i);
         r2a = rf_addr_t'(31 - i);
         #1;
         check($sformatf("rst_r1d[%0d]", i), r1d, 32'h0);
         check($sformatf("rst_r2d[%0d]", 31 - i), r2d, 32'h0);
      end

      // 2: write gated by enable
      we = 1'b0; wa = 5'd19; wd = 32'd121;
      tick();
      we = 1'b1; wa = 5'd13; wd = 32'd45;
      tick();
      we = 1'b0;
      r1a = 5'd19; r2a = 5'd13;
      #1;
      check("we0_r19", r1d, 32'h0);
      check("we1_r13", r2d, 32'd45);

      // 3: port independence
      r1a = 5'd13;
      #1;
      check("p1_r13", r1d, 32'd45);
      check("p2_r13", r2d, 32'd45);
      r1a = 5'd19; r2a = 5'd19;
      #1;
      check("p1_r19", r1d, 32'h0);
      check("p2_r19", r2d, 32'h0);

      // 4: register 0 hardwired
      we = 1'b1; wa = 5'd0; wd = 32'hDEADBEEF;
      tick();
      we = 1'b0; r1a = 5'd0; r2a = 5'd0;
      #1;
      check("r0_p1", r1d, 32'h0);
      check("r0_p2", r2d, 32'h0);

      // 5: no bypass, then top address full width
      we = 1'b1; wa = 5'd7; wd = 32'h1234_5678; r1a = 5'd7;
      #1;
      check("nobyp_pre", r1d, 32'h0);
      tick();
      check("nobyp_post", r1d, 32'h1234_5678);
      wa = 5'd31; wd = 32'hFFFF_FFFF;
      tick();
      we = 1'b0; r2a = 5'd31;
      #1;
      check("r31_ones", r2d, 32'hFFFF_FFFF);
      r2a = 5'd13;
      #1;
      check("r13_kept", r2d, 32'd45);
      check("r7_kept", r1d, 32'h1234_5678);

      // 6: async reset between edges, and a write coinciding with reset is lost
      #2 reset = 1'b1;
      #1;
      r1a = 5'd7; r2a = 5'd31;
      #1;
      check("arst_r7", r1d, 32'h0);
      check("arst_r31", r2d, 32'h0);
      r1a = 5'd13;
      #1;
      check("arst_r13", r1d, 32'h0);
      we = 1'b1; wa = 5'd5; wd = 32'hAAAA_5555;
      tick();
      reset = 1'b0; we = 1'b0;
      r1a = 5'd5;
      #1;
      check("rst_write_lost", r1d, 32'h0);
      tick();
      check("rst_write_lost2", r1d, 32'h0);
      we = 1'b1; wa = 5'd5; wd = 32'h0000_0055;
      tick();
      we = 1'b0;
      #1;
      check("post_rst_write", r1d, 32'h0000_0055);
      r2a = 5'd4;
      #1;
      check("neighbour_r4", r2d, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
